// File: rtl/capi_parerr_ctl.sv
// capi_parerr_ctl
// Central controller for the AFU per-interface parity checkers.
// Collects checker error pulses into sticky status, captures the first error,
// counts error cycles, raises one interrupt per error episode, and sequences
// a parity-error injection self-test with a timeout.
//
// State table (report FSM)
//   R_IDLE | no error episode open, interrupt low
//   R_PEND | error seen, o_int_v held high until i_int_ack
//   R_ACKD | interrupt acknowledged, status keeps updating until i_clr
// State table (inject FSM)
//   I_IDLE | ready for an injection request
//   I_FIRE | force bad parity into the latched source for one cycle
//   I_WAIT | wait for the matching checker to fire, or time out
//
// Ports
//   clk, reset      clock, synchronous active-low reset
//   i_err, i_mask   checker error pulses and per-bit ignore mask
//   i_clr           clear all status and close the error episode
//   o_sticky        sticky per-checker status
//   o_first_v/_id   first-error capture
//   o_cnt           saturating count of cycles with an unmasked error
//   o_int_v         interrupt level, i_int_ack acknowledges
//   i_inj_v/_sel    injection request and checker index
//   o_inj_rdy       inject FSM idle
//   o_inj           one-hot force-bad-parity pulse
//   o_inj_done/fail completion pulse and timeout flag
module capi_parerr_ctl #(
    parameter int nerr  = 8,
    parameter int idw   = 3,
    parameter int cntw  = 16,
    parameter int injto = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [nerr-1:0] i_err,
    input  logic [nerr-1:0] i_mask,
    input  logic            i_clr,
    output logic [nerr-1:0] o_sticky,
    output logic            o_first_v,
    output logic [idw-1:0]  o_first_id,
    output logic [cntw-1:0] o_cnt,
    output logic            o_int_v,
    input  logic            i_int_ack,
    input  logic            i_inj_v,
    input  logic [idw-1:0]  i_inj_sel,
    output logic            o_inj_rdy,
    output logic [nerr-1:0] o_inj,
    output logic            o_inj_done,
    output logic            o_inj_fail
);

    localparam int tmrw = $clog2(injto + 1);
    localparam logic [tmrw-1:0] tmr_load = tmrw'(injto - 1);

    typedef enum logic [1:0] {R_IDLE, R_PEND, R_ACKD} rpt_state_t;
    typedef enum logic [1:0] {I_IDLE, I_FIRE, I_WAIT} inj_state_t;

    rpt_state_t      rpt_state, rpt_next;
    inj_state_t      inj_state, inj_next;
    logic [nerr-1:0] e;
    logic            any_e;
    logic [idw-1:0]  low_idx;
    logic [idw-1:0]  inj_sel;
    logic [tmrw-1:0] tmr;
    logic            inj_accept;
    logic            inj_hit;

    assign e     = i_err & ~i_mask;
    assign any_e = |e;

    // Scan downward so the lowest set index wins.
    always_comb begin
        low_idx = '0;
        for (int i = nerr - 1; i >= 0; i--) begin
            if (e[i]) low_idx = idw'(i);
        end
    end

    // Error status; a clear discards the same cycle's errors.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_sticky   <= '0;
            o_first_v  <= 1'b0;
            o_first_id <= '0;
            o_cnt      <= '0;
        end else if (i_clr) begin
            o_sticky   <= '0;
            o_first_v  <= 1'b0;
            o_first_id <= '0;
            o_cnt      <= '0;
        end else begin
            o_sticky <= o_sticky | e;
            if (any_e && (o_cnt != '1)) o_cnt <= o_cnt + cntw'(1);
            if (!o_first_v && any_e) begin
                o_first_v  <= 1'b1;
                o_first_id <= low_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) rpt_state <= R_IDLE;
        else        rpt_state <= rpt_next;
    end

    always_comb begin
        rpt_next = rpt_state;
        case (rpt_state)
            R_IDLE:  if (any_e) rpt_next = R_PEND;
            R_PEND:  if (i_int_ack) rpt_next = R_ACKD;
            R_ACKD:  rpt_next = R_ACKD;
            default: rpt_next = R_IDLE;
        endcase
        if (i_clr) rpt_next = R_IDLE;
    end

    assign o_int_v = (rpt_state == R_PEND);

    // Out-of-range selections are dropped rather than latched.
    assign inj_accept = (inj_state == I_IDLE) && i_inj_v && (int'(i_inj_sel) < nerr);
    // The hit looks at the raw checker output so a masked source can still be tested.
    assign inj_hit    = i_err[inj_sel];

    always_ff @(posedge clk) begin
        if (!reset) begin
            inj_state <= I_IDLE;
            inj_sel   <= '0;
            tmr       <= '0;
        end else begin
            inj_state <= inj_next;
            if (inj_accept) inj_sel <= i_inj_sel;
            if (inj_state == I_FIRE)                   tmr <= tmr_load;
            else if (inj_state == I_WAIT && tmr != '0) tmr <= tmr - tmrw'(1);
        end
    end

    // Down-counter terminal count at zero equals an up-count reaching injto-1.
    always_comb begin
        inj_next   = inj_state;
        o_inj      = '0;
        o_inj_done = 1'b0;
        o_inj_fail = 1'b0;
        case (inj_state)
            I_IDLE: if (inj_accept) inj_next = I_FIRE;
            I_FIRE: begin
                o_inj    = {{(nerr-1){1'b0}}, 1'b1} << inj_sel;
                inj_next = I_WAIT;
            end
            I_WAIT: begin
                if (inj_hit) begin
                    o_inj_done = 1'b1;
                    inj_next   = I_IDLE;
                end else if (tmr == '0) begin
                    o_inj_done = 1'b1;
                    o_inj_fail = 1'b1;
                    inj_next   = I_IDLE;
                end
            end
            default: inj_next = I_IDLE;
        endcase
    end

    assign o_inj_rdy = (inj_state == I_IDLE);

endmodule

// File: tb/tb_capi_parerr_ctl.sv
// Testbench for capi_parerr_ctl: directed stimulus pushes expectations into
// queues; a negedge monitor pops and compares whenever the DUT presents a
// status-check strobe, an injection pulse or an injection completion.
module tb_capi_parerr_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  i_err;
    logic [7:0]  i_mask;
    logic        i_clr;
    logic [7:0]  o_sticky;
    logic        o_first_v;
    logic [2:0]  o_first_id;
    logic [15:0] o_cnt;
    logic        o_int_v;
    logic        i_int_ack;
    logic        i_inj_v;
    logic [2:0]  i_inj_sel;
    logic        o_inj_rdy;
    logic [7:0]  o_inj;
    logic        o_inj_done;
    logic        o_inj_fail;

    logic [7:0]  err_drv = '0;
    logic        lb_en   = 1'b0;
    logic [7:0]  lb_d1   = '0;
    logic [7:0]  lb_d2   = '0;
    logic        chk_req = 1'b0;
    int          cyc     = 0;
    int          inj_cyc = 0;
    int          done_cnt = 0;
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        string       name;
        logic [7:0]  sticky;
        logic        fv;
        logic [2:0]  fid;
        logic [15:0] cnt;
        logic        intv;
        logic        rdy;
    } stat_t;

    typedef struct {
        logic fail;
        int   delay;
    } done_t;

    stat_t      stat_q[$];
    logic [7:0] inj_q[$];
    done_t      done_q[$];

    capi_parerr_ctl #(.nerr(8), .idw(3), .cntw(16), .injto(15)) dut (
        .clk(clk), .reset(reset), .i_err(i_err), .i_mask(i_mask), .i_clr(i_clr),
        .o_sticky(o_sticky), .o_first_v(o_first_v), .o_first_id(o_first_id),
        .o_cnt(o_cnt), .o_int_v(o_int_v), .i_int_ack(i_int_ack),
        .i_inj_v(i_inj_v), .i_inj_sel(i_inj_sel), .o_inj_rdy(o_inj_rdy),
        .o_inj(o_inj), .o_inj_done(o_inj_done), .o_inj_fail(o_inj_fail)
    );

    always #5 clk = ~clk;

    // Two-cycle loopback from the force-parity output to the checker input.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        lb_d1 <= lb_en ? o_inj : 8'h00;
        lb_d2 <= lb_d1;
    end
    assign i_err = err_drv | lb_d2;

    always @(negedge clk) begin
        if (chk_req) begin
            total++;
            if (stat_q.size() == 0) begin
                bad++;
                $display("FAIL stat_check: strobe with no expectation queued");
            end else begin
                stat_t x;
                x = stat_q.pop_front();
                if ({o_sticky, o_first_v, o_first_id, o_cnt, o_int_v, o_inj_rdy} !==
                    {x.sticky, x.fv, x.fid, x.cnt, x.intv, x.rdy}) begin
                    bad++;
                    $display("FAIL %s: got sticky=%h fv=%b fid=%0d cnt=%h int=%b rdy=%b, want sticky=%h fv=%b fid=%0d cnt=%h int=%b rdy=%b",
                             x.name, o_sticky, o_first_v, o_first_id, o_cnt, o_int_v, o_inj_rdy,
                             x.sticky, x.fv, x.fid, x.cnt, x.intv, x.rdy);
                end
            end
        end
        if (o_inj !== 8'h00) begin
            total++;
            inj_cyc = cyc;
            if (inj_q.size() == 0) begin
                bad++;
                $display("FAIL inj_pulse: unexpected o_inj=%h", o_inj);
            end else begin
                logic [7:0] w;
                w = inj_q.pop_front();
                if (o_inj !== w) begin
                    bad++;
                    $display("FAIL inj_pulse: got o_inj=%h want %h", o_inj, w);
                end
            end
        end
        if (o_inj_done === 1'b1) begin
            total++;
            done_cnt++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL inj_done: unexpected done fail=%b", o_inj_fail);
            end else begin
                done_t d;
                d = done_q.pop_front();
                if (o_inj_fail !== d.fail || (cyc - inj_cyc) != d.delay) begin
                    bad++;
                    $display("FAIL inj_done: got fail=%b delay=%0d want fail=%b delay=%0d",
                             o_inj_fail, cyc - inj_cyc, d.fail, d.delay);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic expect_stat(input string name, input logic [7:0] sticky, input logic fv,
                               input logic [2:0] fid, input logic [15:0] cnt,
                               input logic intv, input logic rdy);
        stat_t x;
        x.name = name; x.sticky = sticky; x.fv = fv; x.fid = fid;
        x.cnt = cnt; x.intv = intv; x.rdy = rdy;
        stat_q.push_back(x);
        chk_req = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        bit seen;
        start = done_cnt;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done_cnt != start) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: no o_inj_done within %0d cycles", name, budget);
        end
    endtask

    task automatic do_clear();
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        done_t d;
        reset = 1'b0; i_mask = '0; i_clr = 1'b0; i_int_ack = 1'b0;
        i_inj_v = 1'b0; i_inj_sel = '0;
        #1;
        repeat (3) step();
        expect_stat("reset", 8'h00, 0, 0, 16'h0, 0, 1);
        step();
        reset = 1'b1;
        step();

        // first error capture and interrupt
        err_drv = 8'h24;
        step();
        err_drv = 8'h00;
        expect_stat("first_err", 8'h24, 1, 2, 16'd1, 1, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            expect_stat("int_hold", 8'h24, 1, 2, 16'd1, 1, 1);
            step();
        end
        i_int_ack = 1'b1;
        step();
        i_int_ack = 1'b0;
        expect_stat("int_ack", 8'h24, 1, 2, 16'd1, 0, 1);
        step();
        err_drv = 8'h80;
        step();
        err_drv = 8'h00;
        expect_stat("ackd_err", 8'hA4, 1, 2, 16'd2, 0, 1);
        step();

        // clear wins over a same-cycle error
        i_clr = 1'b1; err_drv = 8'h02;
        step();
        i_clr = 1'b0; err_drv = 8'h00;
        expect_stat("clr_prio", 8'h00, 0, 0, 16'd0, 0, 1);
        step();
        err_drv = 8'h02;
        step();
        err_drv = 8'h00;
        expect_stat("after_clr", 8'h02, 1, 1, 16'd1, 1, 1);
        step();
        i_mask = 8'h08; err_drv = 8'h08;
        step();
        i_mask = 8'h00; err_drv = 8'h00;
        expect_stat("masked", 8'h02, 1, 1, 16'd1, 1, 1);
        step();
        do_clear();
        expect_stat("clr2", 8'h00, 0, 0, 16'd0, 0, 1);
        step();

        // counter saturation
        err_drv = 8'h01;
        repeat (70000) step();
        err_drv = 8'h00;
        expect_stat("cnt_sat", 8'h01, 1, 0, 16'hFFFF, 1, 1);
        step();
        err_drv = 8'h01;
        step();
        err_drv = 8'h00;
        expect_stat("cnt_hold", 8'h01, 1, 0, 16'hFFFF, 1, 1);
        step();
        do_clear();
        expect_stat("clr3", 8'h00, 0, 0, 16'd0, 0, 1);
        step();

        // injection with loopback: checker fires 2 cycles after o_inj
        lb_en = 1'b1;
        inj_q.push_back(8'h20);
        d.fail = 1'b0; d.delay = 2;
        done_q.push_back(d);
        i_inj_v = 1'b1; i_inj_sel = 3'd5;
        step();
        i_inj_v = 1'b0;
        wait_done("inj_pass", 40);
        expect_stat("inj_pass_stat", 8'h20, 1, 5, 16'd1, 1, 1);
        step();
        lb_en = 1'b0;
        do_clear();

        // injection timeout, requests during WAIT ignored
        inj_q.push_back(8'h08);
        d.fail = 1'b1; d.delay = 15;
        done_q.push_back(d);
        i_inj_v = 1'b1; i_inj_sel = 3'd3;
        step();
        i_inj_v = 1'b0;
        repeat (4) step();
        i_inj_v = 1'b1; i_inj_sel = 3'd1;
        expect_stat("busy_rdy", 8'h00, 0, 0, 16'd0, 0, 0);
        step();
        i_inj_v = 1'b0;
        wait_done("inj_timeout", 40);
        expect_stat("timeout_stat", 8'h00, 0, 0, 16'd0, 0, 1);
        step();

        // reset mid-WAIT
        inj_q.push_back(8'h04);
        i_inj_v = 1'b1; i_inj_sel = 3'd2;
        step();
        i_inj_v = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        step();
        expect_stat("reset_wait", 8'h00, 0, 0, 16'd0, 0, 1);
        step();
        reset = 1'b1;
        repeat (25) step();

        total++;
        if (stat_q.size() != 0 || inj_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL queues_empty: stat=%0d inj=%0d done=%0d left, want 0",
                     stat_q.size(), inj_q.size(), done_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
